// File: rtl/medidor_periodo_pkg.sv
// rtl/medidor_periodo_pkg.sv - shared state encoding and defaults for the period meter
package medidor_periodo_pkg;

   // Default counter width and timeout (in clockOriginal cycles)
   localparam int LARGURA_PADRAO  = 25;
   localparam int LIMITE_PADRAO   = 20000000;

   // Cycles after reset release during which iniciar is not accepted,
   // long enough for the synchronizer to flush a high sinalEntrada
   localparam int CICLOS_BLOQUEIO = 3;

   typedef enum logic [1:0] {
      OCIOSO        = 2'd0,
      ESPERA_BORDA1 = 2'd1,
      CONTANDO      = 2'd2,
      FIM           = 2'd3
   } estado_t;

endpackage

// File: rtl/sincronizador_borda.sv
// rtl/sincronizador_borda.sv - 2-flop synchronizer plus rising-edge detector
module sincronizador_borda (
   input  logic clk,
   input  logic rst,
   input  logic sinal_assinc,
   output logic borda
);

   logic sinc1_q, sinc1_d;
   logic sinc2_q, sinc2_d;
   logic anterior_q, anterior_d;

   // Shift chain: two metastability flops followed by the edge-history flop
   always_comb begin
      sinc1_d    = sinal_assinc;
      sinc2_d    = sinc1_q;
      anterior_d = sinc2_q;
   end

   // Chain registers, cleared so a high input after reset never looks like an old level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sinc1_q    <= 1'b0;
         sinc2_q    <= 1'b0;
         anterior_q <= 1'b0;
      end else begin
         sinc1_q    <= sinc1_d;
         sinc2_q    <= sinc2_d;
         anterior_q <= anterior_d;
      end
   end

   // One-cycle pulse in the cycle after the synchronized level rises
   always_comb begin
      borda = sinc2_q & ~anterior_q;
   end

endmodule

// File: rtl/medidor_periodo.sv
// rtl/medidor_periodo.sv - measures the period of a slow asynchronous signal in clock cycles
module medidor_periodo
   import medidor_periodo_pkg::*;
#(
   parameter int LARGURA = LARGURA_PADRAO,
   parameter int LIMITE  = LIMITE_PADRAO
) (
   input  logic               clockOriginal,
   input  logic               reset,
   input  logic               sinalEntrada,
   input  logic               iniciar,
   output logic [LARGURA-1:0] periodo,
   output logic               valido,
   output logic               ocupado,
   output logic               estouro
);

   localparam logic [LARGURA-1:0] ULTIMA_CONTAGEM  = LARGURA'(LIMITE - 1);
   localparam logic [LARGURA-1:0] UM               = LARGURA'(1);
   localparam logic [1:0]         BLOQUEIO_INICIAL = 2'(CICLOS_BLOQUEIO);

   estado_t            estado_q, estado_d;
   logic [LARGURA-1:0] contador_q, contador_d;
   logic [LARGURA-1:0] periodo_q, periodo_d;
   logic               estouro_q, estouro_d;
   logic [1:0]         bloqueio_q, bloqueio_d;

   logic               borda;
   logic               limite_atingido;
   logic               partida;

   sincronizador_borda u_sincronizador (
      .clk          (clockOriginal),
      .rst          (reset),
      .sinal_assinc (sinalEntrada),
      .borda        (borda)
   );

   // Shared decode: timeout reached, and a start request that is allowed right now
   always_comb begin
      limite_atingido = (contador_q == ULTIMA_CONTAGEM);
      partida         = iniciar && (bloqueio_q == 2'd0);
   end

   // State and datapath registers
   always_ff @(posedge clockOriginal or posedge reset) begin
      if (reset) begin
         estado_q   <= OCIOSO;
         contador_q <= '0;
         periodo_q  <= '0;
         estouro_q  <= 1'b0;
         bloqueio_q <= BLOQUEIO_INICIAL;
      end else begin
         estado_q   <= estado_d;
         contador_q <= contador_d;
         periodo_q  <= periodo_d;
         estouro_q  <= estouro_d;
         bloqueio_q <= bloqueio_d;
      end
   end

   // Next state: a borda always wins over a timeout in the same cycle
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         OCIOSO: begin
            if (partida) estado_d = ESPERA_BORDA1;
         end
         ESPERA_BORDA1: begin
            if (borda)                estado_d = CONTANDO;
            else if (limite_atingido) estado_d = OCIOSO;
         end
         CONTANDO: begin
            if (borda)                estado_d = FIM;
            else if (limite_atingido) estado_d = OCIOSO;
         end
         FIM:     estado_d = OCIOSO;
         default: estado_d = OCIOSO;
      endcase
   end

   // Counter, result and overflow flag; counter freezes at the timeout so it never wraps
   always_comb begin
      contador_d = contador_q;
      periodo_d  = periodo_q;
      estouro_d  = estouro_q;
      bloqueio_d = (bloqueio_q != 2'd0) ? bloqueio_q - 2'd1 : bloqueio_q;
      case (estado_q)
         OCIOSO: begin
            if (partida) begin
               contador_d = '0;
               estouro_d  = 1'b0;
            end
         end
         ESPERA_BORDA1: begin
            if (borda)                contador_d = '0;
            else if (limite_atingido) estouro_d  = 1'b1;
            else                      contador_d = contador_q + UM;
         end
         CONTANDO: begin
            if (borda)                periodo_d  = contador_q + UM;
            else if (limite_atingido) estouro_d  = 1'b1;
            else                      contador_d = contador_q + UM;
         end
         default: begin
         end
      endcase
   end

   // Outputs decoded from the current state and held registers
   always_comb begin
      valido  = (estado_q == FIM);
      ocupado = (estado_q == ESPERA_BORDA1) || (estado_q == CONTANDO);
      periodo = periodo_q;
      estouro = estouro_q;
   end

endmodule

// File: tb/tb_medidor_periodo.sv
// tb/tb_medidor_periodo.sv - self-checking bench for medidor_periodo
module tb_medidor_periodo;

   localparam int LARGURA = 25;
   localparam int LIMITE  = 100;

   logic               clockOriginal = 1'b0;
   logic               reset         = 1'b1;
   logic               sinalEntrada  = 1'b0;
   logic               iniciar       = 1'b0;
   logic [LARGURA-1:0] periodo;
   logic               valido;
   logic               ocupado;
   logic               estouro;

   typedef struct {
      int alto;
      int baixo;
      int atraso;
      bit extra;
      int exp_val;
      int exp_per;
      bit exp_est;
   } vetor_t;

   vetor_t tabela [7];
   int     n_checks = 0;
   int     n_pass   = 0;
   int     n_valido = 0;
   longint modelo_periodo = 0;

   medidor_periodo #(.LARGURA(LARGURA), .LIMITE(LIMITE)) dut (
      .clockOriginal (clockOriginal),
      .reset         (reset),
      .sinalEntrada  (sinalEntrada),
      .iniciar       (iniciar),
      .periodo       (periodo),
      .valido        (valido),
      .ocupado       (ocupado),
      .estouro       (estouro)
   );

   always #5 clockOriginal = ~clockOriginal;

   // Running count of valido pulses, sampled away from the active edge
   always @(negedge clockOriginal) begin
      if (valido) n_valido = n_valido + 1;
   end

   task automatic tick();
      @(posedge clockOriginal);
      #1;
   endtask

   task automatic chk(input string nome, input longint atual, input longint esperado);
      n_checks++;
      if (atual == esperado) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
   endtask

   // One measurement: start, wait atraso cycles, then one full period alto+baixo
   task automatic medir(input int alto, input int baixo, input int atraso, input bit extra,
                        input int exp_val, input longint exp_per, input bit exp_est,
                        input string nome);
      int p;
      int lim;
      int r;
      int base;
      p   = alto + baixo;
      lim = (p < LIMITE) ? p : LIMITE;
      r   = extra ? int'($urandom_range(1, lim - 1)) : -1;
      sinalEntrada = 1'b0;
      repeat (6) tick();
      base = n_valido;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      chk($sformatf("%s ocupado_inicio", nome), ocupado, 1);
      chk($sformatf("%s estouro_limpo", nome), estouro, 0);
      repeat (atraso) tick();
      for (int c = 0; c < p; c++) begin
         sinalEntrada = (c < alto);
         iniciar      = (c == r);
         tick();
      end
      iniciar      = 1'b0;
      sinalEntrada = 1'b1;
      repeat (110) tick();
      sinalEntrada = 1'b0;
      repeat (5) tick();
      chk($sformatf("%s n_valido", nome), n_valido - base, exp_val);
      chk($sformatf("%s periodo", nome), periodo, exp_per);
      chk($sformatf("%s estouro", nome), estouro, exp_est);
      chk($sformatf("%s ocupado_fim", nome), ocupado, 0);
   endtask

   initial begin
      int base;
      int espera;
      int alto;
      int baixo;
      int p;

      tabela[0] = '{5,  5,  3,  1'b0, 1, 10,  1'b0};
      tabela[1] = '{50, 50, 10, 1'b0, 1, 100, 1'b0};
      tabela[2] = '{50, 51, 10, 1'b0, 0, 100, 1'b1};
      tabela[3] = '{5,  5,  2,  1'b1, 1, 10,  1'b0};
      tabela[4] = '{1,  1,  0,  1'b0, 1, 2,   1'b0};
      tabela[5] = '{1,  99, 20, 1'b1, 1, 100, 1'b0};
      tabela[6] = '{60, 60, 5,  1'b0, 0, 100, 1'b1};

      // Reset state
      tick();
      tick();
      chk("reset periodo", periodo, 0);
      chk("reset valido", valido, 0);
      chk("reset ocupado", ocupado, 0);
      chk("reset estouro", estouro, 0);
      reset = 1'b0;
      repeat (5) tick();

      // Fixed vectors
      for (int i = 0; i < 7; i++) begin
         medir(tabela[i].alto, tabela[i].baixo, tabela[i].atraso, tabela[i].extra,
               tabela[i].exp_val, tabela[i].exp_per, tabela[i].exp_est,
               $sformatf("vetor%0d", i));
      end
      modelo_periodo = 100;

      // Signal stuck low: timeout exactly LIMITE cycles after acceptance
      sinalEntrada = 1'b0;
      repeat (6) tick();
      base = n_valido;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      espera = 0;
      while (!estouro && espera < 200) begin
         tick();
         espera++;
      end
      chk("timeout ciclos", espera, LIMITE);
      chk("timeout ocupado", ocupado, 0);
      repeat (10) tick();
      chk("timeout estouro_retido", estouro, 1);
      chk("timeout n_valido", n_valido - base, 0);
      chk("timeout periodo", periodo, modelo_periodo);

      // Random periods against the arithmetic model
      for (int i = 0; i < 12; i++) begin
         alto  = int'($urandom_range(1, 60));
         baixo = int'($urandom_range(1, 60));
         p     = alto + baixo;
         if (p <= LIMITE) begin
            modelo_periodo = p;
            medir(alto, baixo, int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)),
                  1, modelo_periodo, 1'b0, $sformatf("aleat%0d", i));
         end else begin
            medir(alto, baixo, int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)),
                  0, modelo_periodo, 1'b1, $sformatf("aleat%0d", i));
         end
      end

      // Reset while counting aborts the measurement immediately
      sinalEntrada = 1'b0;
      repeat (6) tick();
      base = n_valido;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      sinalEntrada = 1'b1;
      repeat (5) tick();
      sinalEntrada = 1'b0;
      repeat (3) tick();
      chk("abort ocupado_antes", ocupado, 1);
      #1 reset = 1'b1;
      #1;
      chk("abort ocupado", ocupado, 0);
      chk("abort periodo", periodo, 0);
      chk("abort estouro", estouro, 0);
      chk("abort valido", valido, 0);
      tick();
      tick();
      reset = 1'b0;
      modelo_periodo = 0;
      repeat (10) tick();
      chk("abort n_valido", n_valido - base, 0);
      medir(5, 5, 4, 1'b0, 1, 10, 1'b0, "pos_reset");

      // High input across reset; early iniciar ignored, no spurious borda
      sinalEntrada = 1'b1;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      modelo_periodo = 0;
      base = n_valido;
      iniciar = 1'b1;
      repeat (3) tick();
      iniciar = 1'b0;
      chk("bloqueio ocupado", ocupado, 0);
      repeat (3) tick();
      chk("bloqueio ocupado_apos", ocupado, 0);
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      chk("bloqueio aceito", ocupado, 1);
      espera = 0;
      while (!estouro && espera < 200) begin
         tick();
         espera++;
      end
      chk("bloqueio estouro", estouro, 1);
      chk("bloqueio n_valido", n_valido - base, 0);
      chk("bloqueio periodo", periodo, modelo_periodo);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/medidor_periodo.md
MEDIDOR_PERIODO -- requirements
Module: medidor_periodo

Interface
REQ-001 Parameter LARGURA, 25, width of the period counter and of the periodo output.
REQ-002 Parameter LIMITE, 20000000, timeout in clockOriginal cycles; SHALL satisfy 2 <= LIMITE <= 2^LARGURA-1.
REQ-003 Port clockOriginal  input  1  the only clock; all state SHALL be on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port sinalEntrada  input  1  slow signal asynchronous to clockOriginal (e.g. divided clock) whose period is measured.
REQ-006 Port iniciar  input  1  synchronous start request, sampled only in state OCIOSO.
REQ-007 Port periodo  output  LARGURA  last measured period in clockOriginal cycles.
REQ-008 Port valido  output  1  one-cycle pulse when periodo is updated.
REQ-009 Port ocupado  output  1  high while a measurement is in progress.
REQ-010 Port estouro  output  1  timeout flag; sticky until the next accepted iniciar.

Function
REQ-011 sinalEntrada SHALL pass through a 2-flop synchronizer; a rising edge (borda) SHALL be a synchronized 0->1 transition, detected exactly one cycle after the second flop changes.
REQ-012 FSM states: OCIOSO, ESPERA_BORDA1, CONTANDO, FIM.
REQ-013 OCIOSO: iniciar=1 -> ESPERA_BORDA1, contador<=0, estouro<=0; bordas SHALL be discarded.
REQ-014 ESPERA_BORDA1: borda -> CONTANDO, contador<=0; otherwise contador increments.
REQ-015 CONTANDO: contador increments each cycle; borda -> FIM, periodo<=contador+1.
REQ-016 Result: periodo SHALL equal the cycle distance between the two detected bordas; sinalEntrada with period N cycles SHALL yield periodo=N.
REQ-017 FIM lasts one cycle with valido=1, then OCIOSO; iniciar in FIM SHALL be ignored.
REQ-018 Timeout: in ESPERA_BORDA1 or CONTANDO, contador==LIMITE-1 with no borda -> OCIOSO, estouro<=1, valido stays 0, periodo unchanged.
REQ-019 Simultaneous borda and contador==LIMITE-1 in CONTANDO: borda wins, periodo=LIMITE, no estouro.
REQ-020 ocupado SHALL be 1 exactly in ESPERA_BORDA1 and CONTANDO.
REQ-021 iniciar while ocupado=1 SHALL be ignored and SHALL NOT restart the measurement.
REQ-022 contador SHALL never wrap; the timeout (REQ-018) bounds it below 2^LARGURA.
REQ-023 periodo SHALL hold its value until the next valido.

Reset
REQ-024 reset=1 SHALL immediately force: state OCIOSO, contador 0, periodo 0, valido 0, ocupado 0, estouro 0, synchronizer and edge flops 0.
REQ-025 reset asserted mid-measurement SHALL abort it with no valido pulse.
REQ-026 iniciar SHALL be ignored during the first 3 cycles after reset release, so that no spurious borda from a high sinalEntrada is counted.

Structure
REQ-027 The FSM state encoding and the LARGURA/LIMITE defaults SHALL live in the shared project package.
REQ-028 One sub-module, sincronizador_borda, SHALL hold the 2-flop synchronizer and the rising-edge detector; it outputs a 1-cycle borda pulse.

Verification
REQ-029 LIMITE=100; sinalEntrada toggles every 5 cycles; iniciar pulse -> valido once, periodo=10, estouro=0.
REQ-030 LIMITE=100; sinalEntrada held 0; iniciar -> estouro=1 within 100 cycles of acceptance, no valido, periodo unchanged.
REQ-031 LIMITE=100; sinalEntrada period exactly 100 -> periodo=100, estouro=0 (REQ-019 boundary); period 101 -> estouro=1.
REQ-032 Measurement running, second iniciar pulse mid-count -> single valido, periodo=10 (request ignored).
REQ-033 reset pulsed during CONTANDO -> all outputs 0 at once, no valido; a later iniciar measures normally, periodo=10.
REQ-034 sinalEntrada=1 during reset; iniciar on the first cycle after release -> ignored, ocupado stays 0.
